prbs_checker: RTL and testbench
===============================

Name: prbs_checker

Overview:
- Receive-side counterpart of the team's Galois LFSR PRBS generator.
- Takes the serial pseudo-random bit stream that generator produces with the same POLY, self-synchronises to it, and then reports bit errors.
- Sits at the receive end of a link or loopback and provides lock status, an error pulse, and saturating error and bit counters for BER measurement.

Parameters:
- POLY, 32'hA3000000: generator polynomial, identical encoding to the generator. WIDTH = $size(POLY).
- LOCK_MATCHES, 64: number of consecutive correct predictions needed to declare lock.
- LOSS_ERRORS, 8: number of consecutive mispredictions while locked that drops lock.
- CNT_W, 32: width of the error and bit counters.

Ports:
- clock, input, 1: single clock. All logic is on posedge.
- reset_n, input, 1: asynchronous, active-low reset.
- clear, input, 1: synchronous clear of the counters. Lock state is not affected.
- bit_valid_i, input, 1: qualifies bit_i. Gaps are allowed.
- bit_i, input, 1: received PRBS bit.
- locked_o, output, 1: checker is locked.
- error_o, output, 1: one-cycle pulse marking a mispredicted bit while locked.
- err_count_o, output, CNT_W: count of errors while locked. Saturating.
- bit_count_o, output, CNT_W: count of bits checked while locked. Saturating.

Behaviour:
- Prediction:
  - TAPS = {1'b1, POLY[WIDTH-2:0]}.
  - hist[WIDTH-1:0] holds past bits; hist[0] is the newest.
  - pred = ^(hist & TAPS). This is the recurrence obeyed by the generator output: o[n] = XOR over i of TAPS[i]&o[n-1-i].
- Reset (reset_n=0, async):
  - state = SEARCH; hist = 0; fill counter = 0; match counter = 0; miss counter = 0.
  - locked_o = 0, error_o = 0, err_count_o = 0, bit_count_o = 0.
- Cycles without bit_valid_i: no state change, error_o = 0.
- State SEARCH, on each valid bit:
  - hist shifts in bit_i.
  - While fill < WIDTH: fill increments and no comparison is made.
  - Once fill = WIDTH: if bit_i == pred and hist != 0, match++; otherwise match = 0.
  - When match reaches LOCK_MATCHES, go to LOCKED. The all-zero hist guard prevents false lock on a stuck-at-0 line.
- State LOCKED, on each valid bit:
  - hist shifts in pred, not bit_i (flywheel), so one line error counts once rather than WIDTH-weight times.
  - bit_count increments.
  - If bit_i != pred: err_count increments, error_o = 1 in the next cycle, miss++.
  - Otherwise miss = 0.
  - When miss reaches LOSS_ERRORS, go to SEARCH with fill = 0, match = 0, miss = 0, hist = 0. Counters hold their values.
- Latency:
  - locked_o, error_o and both counters are registered.
  - They reflect a valid bit one clock after the edge that samples it.
  - locked_o rises one clock after the sampling edge of the LOCK_MATCHES-th matching bit.
- Counters:
  - Saturate at all-ones and never wrap.
  - Count only in LOCKED. The bit that causes the transition into LOCKED is not counted.
  - The bit that causes loss of lock is counted, in both counters.
- clear and valid bit in the same cycle:
  - Both counters become 0 and that bit is not counted.
  - error_o still pulses for that bit, and the state machine processes the bit normally.
- Reset mid-operation: immediate return to the reset values above, regardless of state.

Decomposition:
- Package prbs_pkg:
  - state enum {SEARCH, LOCKED}.
  - Function taps_of(poly), returning {1'b1, poly[W-2:0]}. The generator and checker share it.
- Sub-module sat_counter #(W): clock, reset_n, clr, inc, q. Instantiated twice, for the error and bit counters.
- Predictor and FSM stay in prbs_checker.

Test Plan:
- Default-parameter generator (preset released, seed all-ones) feeding bit_valid_i=1 continuously:
  - locked_o rises one clock after the 96th valid bit (32 fill + 64 matches).
  - error_o never pulses; err_count_o = 0; bit_count_o increments once per clock.
- After lock, invert exactly one bit:
  - error_o pulses exactly once; err_count_o = 1; locked_o stays 1.
  - Subsequent bits match.
- After lock, invert 8 consecutive bits:
  - err_count_o = 8; locked_o falls one clock after the 8th.
  - Relock occurs 96 valid bits later with counters preserved.
- bit_i held at 0 for 1000 valid bits, then held at 1 for 1000 valid bits:
  - locked_o stays 0 throughout; counters stay 0.
- Same stream with bit_valid_i toggling in a random pattern:
  - Lock is reached after 96 valid bits, and counts equal the number of valid bits only.
- clear asserted mid-lock together with a flipped bit, then reset_n pulsed low asynchronously mid-lock:
  - On clear, counters go to 0 and error_o pulses for the flipped bit.
  - On reset, all outputs are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS generator/checker pair.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package prbs_pkg;

    localparam int MAX_W = 64;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // Feedback taps: the top bit of a w-bit polynomial is always a tap.
    function automatic logic [MAX_W-1:0] taps_of(input logic [MAX_W-1:0] poly, input int w);
        logic [MAX_W-1:0] t;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w - 1)
                t[i] = poly[i];
            else
                t[i] = (i == w - 1);
        end
        return t;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Latency: q reflects clr/inc one clock after the sampling edge.
// Backpressure: none; holds at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc && (q != '1))
            q <= q + 1'b1;
    end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: locks to a Galois-LFSR stream, counts bit errors.
// Latency: locked_o, error_o and counters are registered, one clock after the sampling edge.
// Backpressure: none; bit_valid_i may gap freely, idle cycles change nothing.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter logic [31:0] POLY         = 32'hA3000000,
    parameter int          LOCK_MATCHES = 64,
    parameter int          LOSS_ERRORS  = 8,
    parameter int          CNT_W        = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             bit_valid_i,
    input  logic             bit_i,
    output logic             locked_o,
    output logic             error_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic [CNT_W-1:0] bit_count_o
);

    localparam int WIDTH   = $size(POLY);
    localparam int FILL_W  = $clog2(WIDTH + 1);
    localparam int MATCH_W = $clog2(LOCK_MATCHES + 1);
    localparam int MISS_W  = $clog2(LOSS_ERRORS + 1);

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(taps_of(MAX_W'(POLY), WIDTH));

    state_e             state;
    logic [WIDTH-1:0]   hist;
    logic [FILL_W-1:0]  fill;
    logic [MATCH_W-1:0] match;
    logic [MISS_W-1:0]  miss;

    logic pred;
    logic mismatch;
    logic bit_inc;
    logic err_inc;

    assign pred     = ^(hist & TAPS);
    assign mismatch = bit_i ^ pred;
    assign bit_inc  = bit_valid_i && (state == LOCKED);
    assign err_inc  = bit_inc && mismatch;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= SEARCH;
            hist     <= '0;
            fill     <= '0;
            match    <= '0;
            miss     <= '0;
            locked_o <= 1'b0;
            error_o  <= 1'b0;
        end else begin
            error_o <= 1'b0;
            if (bit_valid_i) begin
                case (state)
                    SEARCH: begin
                        hist <= {hist[WIDTH-2:0], bit_i};
                        if (fill < FILL_W'(WIDTH)) begin
                            fill <= fill + 1'b1;
                        end else if (!mismatch && (hist != '0)) begin
                            // An all-zero history predicts 0 forever; never lock on it.
                            if (match == MATCH_W'(LOCK_MATCHES - 1)) begin
                                state    <= LOCKED;
                                locked_o <= 1'b1;
                                match    <= '0;
                            end else begin
                                match <= match + 1'b1;
                            end
                        end else begin
                            match <= '0;
                        end
                    end
                    LOCKED: begin
                        // Flywheel on the prediction so a line error is not fed back.
                        hist <= {hist[WIDTH-2:0], pred};
                        if (mismatch) begin
                            error_o <= 1'b1;
                            if (miss == MISS_W'(LOSS_ERRORS - 1)) begin
                                state    <= SEARCH;
                                locked_o <= 1'b0;
                                hist     <= '0;
                                fill     <= '0;
                                match    <= '0;
                                miss     <= '0;
                            end else begin
                                miss <= miss + 1'b1;
                            end
                        end else begin
                            miss <= '0;
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (clear),
        .inc     (err_inc),
        .q       (err_count_o)
    );

    sat_counter #(.W(CNT_W)) u_bit_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (clear),
        .inc     (bit_inc),
        .q       (bit_count_o)
    );

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: segment table, hand-written corner sequences, and a
// randomized run against a queue-based reference model of the lock/count rules.
module tb_prbs_checker;

    localparam logic [31:0] POLY = 32'hA3000000;
    localparam logic [31:0] TAPS = {1'b1, POLY[30:0]};
    localparam int W     = 32;
    localparam int LOCK  = 64;
    localparam int LOSS  = 8;
    localparam longint SAT32 = 64'hFFFF_FFFF;
    localparam longint SAT4  = 15;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    logic        bit_valid_i = 1'b0;
    logic        bit_i = 1'b0;
    logic        locked_o, error_o;
    logic [31:0] err_count_o, bit_count_o;
    logic        s_locked, s_error;
    logic [3:0]  s_err, s_bits;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    prbs_checker dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .clear       (clear),
        .bit_valid_i (bit_valid_i),
        .bit_i       (bit_i),
        .locked_o    (locked_o),
        .error_o     (error_o),
        .err_count_o (err_count_o),
        .bit_count_o (bit_count_o)
    );

    prbs_checker #(.CNT_W(4)) dut_s (
        .clock       (clock),
        .reset_n     (reset_n),
        .clear       (clear),
        .bit_valid_i (bit_valid_i),
        .bit_i       (bit_i),
        .locked_o    (s_locked),
        .error_o     (s_error),
        .err_count_o (s_err),
        .bit_count_o (s_bits)
    );

    // ---------------- stream source: o[n] = XOR TAPS[i] & o[n-1-i] ----------------
    logic [31:0] g;

    function automatic bit gen_next();
        bit nb;
        nb = ^(g & TAPS);
        g  = {g[30:0], nb};
        return nb;
    endfunction

    // ---------------- reference model ----------------
    bit     m_locked, m_errp;
    int     m_fill, m_match, m_miss;
    longint m_err, m_bits;
    bit     mh[$];

    task automatic m_reset();
        m_locked = 0; m_errp = 0;
        m_fill = 0; m_match = 0; m_miss = 0;
        m_err = 0; m_bits = 0;
        mh = {};
        for (int i = 0; i < W; i++) mh.push_back(1'b0);
    endtask

    function automatic bit m_pred();
        bit p = 0;
        for (int i = 0; i < W; i++)
            if (TAPS[i]) p ^= mh[i];
        return p;
    endfunction

    task automatic m_step(input bit v, input bit b, input bit clr);
        bit p, nz;
        m_errp = 0;
        if (clr) begin m_err = 0; m_bits = 0; end
        if (!v) return;
        p = m_pred();
        nz = 0;
        foreach (mh[i]) if (mh[i]) nz = 1;
        if (!m_locked) begin
            mh.push_front(b); void'(mh.pop_back());
            if (m_fill < W) m_fill++;
            else if (b == p && nz) begin
                m_match++;
                if (m_match == LOCK) begin m_locked = 1; m_match = 0; end
            end else m_match = 0;
        end else begin
            mh.push_front(p); void'(mh.pop_back());
            if (!clr && m_bits < SAT32) m_bits++;
            if (b != p) begin
                m_errp = 1;
                if (!clr && m_err < SAT32) m_err++;
                m_miss++;
                if (m_miss == LOSS) begin
                    m_locked = 0; m_fill = 0; m_match = 0; m_miss = 0;
                    foreach (mh[i]) mh[i] = 1'b0;
                end
            end else m_miss = 0;
        end
    endtask

    function automatic longint cap4(input longint x);
        return (x > SAT4) ? SAT4 : x;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_raw(input bit v, input bit b, input bit clr);
        @(negedge clock);
        bit_valid_i = v;
        bit_i       = b;
        clear       = clr;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit v, input bit flip, input bit clr);
        bit b;
        b = 1'b0;
        if (v) b = gen_next() ^ flip;
        drive_raw(v, b, clr);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n     = 1'b0;
        bit_valid_i = 1'b0;
        bit_i       = 1'b0;
        clear       = 1'b0;
        g           = '1;
        m_reset();
        #2;
        reset_n = 1'b1;
    endtask

    task automatic check_all(input string tag, input bit lk, input bit er, input longint ec, input longint bc);
        check({tag, "_locked"}, locked_o, lk);
        check({tag, "_error"}, error_o, er);
        check({tag, "_err_cnt"}, err_count_o, ec);
        check({tag, "_bit_cnt"}, bit_count_o, bc);
        check({tag, "_s_err_cnt"}, s_err, cap4(ec));
        check({tag, "_s_bit_cnt"}, s_bits, cap4(bc));
    endtask

    typedef struct {
        int n;
        bit flip;
        bit exp_locked;
        int exp_err;
        int exp_bits;
        int exp_pulses;
    } seg_t;

    seg_t segs[10];

    initial begin
        int pulses;
        bit seen_lock;
        longint seen_cnt;
        int burst;

        segs[0] = '{95, 0, 0, 0,  0, 0};  // fill + 63 matches: not yet locked
        segs[1] = '{ 1, 0, 1, 0,  0, 0};  // 96th bit locks, not counted
        segs[2] = '{10, 0, 1, 0, 10, 0};
        segs[3] = '{ 1, 1, 1, 1, 11, 1};  // single line error
        segs[4] = '{20, 0, 1, 1, 31, 0};
        segs[5] = '{ 7, 1, 1, 8, 38, 7};
        segs[6] = '{ 1, 1, 0, 9, 39, 1};  // 8th consecutive miss drops lock, still counted
        segs[7] = '{95, 0, 0, 9, 39, 0};
        segs[8] = '{ 1, 0, 1, 9, 39, 0};  // relock 96 bits later, counters held
        segs[9] = '{ 5, 0, 1, 9, 44, 0};

        do_reset();
        @(posedge clock); #1;
        check_all("reset", 0, 0, 0, 0);

        // ---- table-driven segments on a continuous stream ----
        for (int s = 0; s < 10; s++) begin
            pulses = 0;
            for (int k = 0; k < segs[s].n; k++) begin
                drive(1'b1, segs[s].flip, 1'b0);
                if (error_o) pulses++;
            end
            check($sformatf("seg%0d_locked", s), locked_o, segs[s].exp_locked);
            check($sformatf("seg%0d_err_cnt", s), err_count_o, segs[s].exp_err);
            check($sformatf("seg%0d_bit_cnt", s), bit_count_o, segs[s].exp_bits);
            check($sformatf("seg%0d_pulses", s), pulses, segs[s].exp_pulses);
            check($sformatf("seg%0d_s_err", s), s_err, cap4(segs[s].exp_err));
            check($sformatf("seg%0d_s_bits", s), s_bits, cap4(segs[s].exp_bits));
        end

        // ---- clear together with a flipped bit, then async reset mid-lock ----
        do_reset();
        repeat (96 + 20) drive(1'b1, 1'b0, 1'b0);
        check_all("pre_clear", 1, 0, 0, 20);
        drive(1'b1, 1'b1, 1'b1);
        check_all("clear_flip", 1, 1, 0, 0);
        drive(1'b1, 1'b0, 1'b0);
        check_all("after_clear", 1, 0, 0, 1);
        drive(1'b1, 1'b1, 1'b0);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check_all("async_reset", 0, 0, 0, 0);
        check("async_reset_s_locked", s_locked, 0);

        // ---- stuck-at-0 then stuck-at-1 line ----
        do_reset();
        seen_lock = 0;
        seen_cnt  = 0;
        for (int k = 0; k < 2000; k++) begin
            drive_raw(1'b1, (k >= 1000), 1'b0);
            seen_lock |= locked_o;
            seen_cnt  |= longint'(err_count_o) | longint'(bit_count_o);
        end
        check("stuck_lock_seen", seen_lock, 0);
        check("stuck_counts_seen", seen_cnt, 0);

        // ---- randomized gaps, error bursts and clears against the model ----
        do_reset();
        burst = 0;
        for (int k = 0; k < 6000; k++) begin
            bit v, f, c, b;
            v = ($urandom_range(0, 9) < 7);
            c = ($urandom_range(0, 499) == 0);
            f = 0;
            if (v && m_locked) begin
                if (burst > 0) begin f = 1; burst--; end
                else if ($urandom_range(0, 299) == 0) begin f = 1; burst = $urandom_range(7, 11); end
                else if ($urandom_range(0, 59) == 0) f = 1;
            end
            b = 1'b0;
            if (v) b = gen_next() ^ f;
            drive_raw(v, b, c);
            m_step(v, b, c);
            check("rnd_locked", locked_o, m_locked);
            check("rnd_error", error_o, m_errp);
            check("rnd_err_cnt", err_count_o, m_err);
            check("rnd_bit_cnt", bit_count_o, m_bits);
            check("rnd_s_err_cnt", s_err, cap4(m_err));
            check("rnd_s_bit_cnt", s_bits, cap4(m_bits));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
